// File: rtl/controller_if.sv
// ---------------------------------------------------------------------------
// controller_if
//
// Groups the signals between the matrix-vector sequencing controller and
// the blocks around it:
//   - register file side : running (start/enable level), width (N), finish
//   - matrix BRAM port   : mbram_clk, mbram_en, mbram_addr[11:0]
//   - vector BRAM port   : vbram_clk, vbram_en, vbram_we, vbram_addr[9:0]
//   - MAC datapath tags  : zero_in, last, rows_done
//
// master : the controller (drives the BRAM ports, tags and finish)
// slave  : the surrounding system (drives running and width)
// ---------------------------------------------------------------------------
interface controller_if;
    logic        running;
    logic [8:0]  width;
    logic        mbram_clk;
    logic        mbram_en;
    logic [11:0] mbram_addr;
    logic        vbram_clk;
    logic        vbram_en;
    logic        vbram_we;
    logic [9:0]  vbram_addr;
    logic        zero_in;
    logic        last;
    logic        rows_done;
    logic        finish;

    modport master (
        input  running, width,
        output mbram_clk, mbram_en, mbram_addr,
        output vbram_clk, vbram_en, vbram_we, vbram_addr,
        output zero_in, last, rows_done, finish
    );

    modport slave (
        output running, width,
        input  mbram_clk, mbram_en, mbram_addr,
        input  vbram_clk, vbram_en, vbram_we, vbram_addr,
        input  zero_in, last, rows_done, finish
    );
endinterface

// File: rtl/controller.sv
// ---------------------------------------------------------------------------
// controller
//
// Sequencing controller for the 6-lane matrix-vector multiply engine.
// Walks an N x N matrix in row groups of 6: for each group it issues N
// matrix/vector reads, waits for the MAC pipeline to drain, then writes the
// group result to vector BRAM address 512+g. zero_in/last tag the first and
// final product of each group as they reach the accumulator.
//
// Ports:
//   clk  : system clock
//   rstn : synchronous active-low reset
//   bus  : controller_if.master (register file, BRAM ports, datapath tags)
//
// Parameters:
//   DELAY_MUL : multiplier pipeline depth (cycles)
//   DELAY_ADD : lane adder-tree depth (cycles)
//   DELAY_ACC : accumulator depth from last to valid result (cycles)
//
// All outputs except the BRAM clocks are registered. The output registers
// are loaded from the values belonging to the *next* state, so the outputs
// seen during a cycle always describe the state occupied in that cycle.
// ---------------------------------------------------------------------------
module controller #(
    parameter int unsigned DELAY_MUL = 2,
    parameter int unsigned DELAY_ADD = 1,
    parameter int unsigned DELAY_ACC = 3
) (
    input  logic          clk,
    input  logic          rstn,
    controller_if.master  bus
);

    // Read latency (1) plus multiplier and adder tree.
    localparam int unsigned L1        = 1 + DELAY_MUL + DELAY_ADD;
    localparam int unsigned DRAIN_LEN = L1 + DELAY_ACC;
    localparam logic [7:0]  DRAIN_LAST = 8'(DRAIN_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [8:0]  n_q, n_d;          // latched matrix dimension
    logic [8:0]  k_q, k_d;          // column index within the group
    logic [8:0]  g_q, g_d;          // row group index
    logic [9:0]  rb_q, rb_d;        // first row of the group (6*g)
    logic [11:0] m_q, m_d;          // running matrix address, never reset between groups
    logic [7:0]  dcnt_q, dcnt_d;    // drain cycle counter

    // Token shift registers: index 0 holds the token of the current issue
    // cycle, index L1 is the tap seen by the datapath L1 cycles later.
    logic [L1:0] zsr_q, zsr_d;
    logic [L1:0] lsr_q, lsr_d;
    logic        ztok, ltok;

    logic        mbram_en_q, mbram_en_d;
    logic [11:0] mbram_addr_q, mbram_addr_d;
    logic        vbram_en_q, vbram_en_d;
    logic        vbram_we_q, vbram_we_d;
    logic [9:0]  vbram_addr_q, vbram_addr_d;
    logic        rows_done_q, rows_done_d;
    logic        finish_q, finish_d;

    // -----------------------------------------------------------------------
    // Next-state and counter logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        k_d     = k_q;
        g_d     = g_q;
        rb_d    = rb_q;
        m_d     = m_q;
        dcnt_d  = dcnt_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.running) begin
                    n_d     = bus.width;
                    k_d     = 9'd0;
                    g_d     = 9'd0;
                    rb_d    = 10'd0;
                    m_d     = 12'd0;
                    state_d = (bus.width == 9'd0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!bus.running) begin
                    state_d = ST_IDLE;
                end else begin
                    m_d = m_q + 12'd1;
                    if (k_q == n_q - 9'd1) begin
                        k_d     = 9'd0;
                        dcnt_d  = 8'd0;
                        state_d = ST_DRAIN;
                    end else begin
                        k_d = k_q + 9'd1;
                    end
                end
            end
            ST_DRAIN: begin
                if (!bus.running) begin
                    state_d = ST_IDLE;
                end else if (dcnt_q == DRAIN_LAST) begin
                    state_d = ST_WRITE;
                end else begin
                    dcnt_d = dcnt_q + 8'd1;
                end
            end
            ST_WRITE: begin
                if (!bus.running) begin
                    state_d = ST_IDLE;
                end else if (rb_q + 10'd6 >= {1'b0, n_q}) begin
                    // This group covered the final rows.
                    state_d = ST_DONE;
                end else begin
                    g_d     = g_q + 9'd1;
                    rb_d    = rb_q + 10'd6;
                    state_d = ST_ISSUE;
                end
            end
            ST_DONE: begin
                if (!bus.running) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output values for the upcoming cycle
    // -----------------------------------------------------------------------
    always_comb begin
        mbram_en_d   = 1'b0;
        mbram_addr_d = 12'd0;
        vbram_en_d   = 1'b0;
        vbram_we_d   = 1'b0;
        vbram_addr_d = 10'd0;
        rows_done_d  = 1'b0;
        finish_d     = 1'b0;
        ztok         = 1'b0;
        ltok         = 1'b0;

        case (state_d)
            ST_ISSUE: begin
                mbram_en_d   = 1'b1;
                mbram_addr_d = m_d;
                vbram_en_d   = 1'b1;
                vbram_addr_d = {1'b0, k_d};
                ztok         = (k_d == 9'd0);
                ltok         = (k_d == n_d - 9'd1);
            end
            ST_WRITE: begin
                vbram_en_d   = 1'b1;
                vbram_we_d   = 1'b1;
                vbram_addr_d = 10'd512 + {1'b0, g_d};
                rows_done_d  = 1'b1;
            end
            ST_DONE: begin
                finish_d = 1'b1;
            end
            default: begin
            end
        endcase

        // Entering IDLE (abort or end of run) flushes in-flight tokens so no
        // stray zero_in/last reach the datapath.
        if (state_d == ST_IDLE) begin
            zsr_d = '0;
            lsr_d = '0;
        end else begin
            zsr_d = {zsr_q[L1-1:0], ztok};
            lsr_d = {lsr_q[L1-1:0], ltok};
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            n_q          <= 9'd0;
            k_q          <= 9'd0;
            g_q          <= 9'd0;
            rb_q         <= 10'd0;
            m_q          <= 12'd0;
            dcnt_q       <= 8'd0;
            zsr_q        <= '0;
            lsr_q        <= '0;
            mbram_en_q   <= 1'b0;
            mbram_addr_q <= 12'd0;
            vbram_en_q   <= 1'b0;
            vbram_we_q   <= 1'b0;
            vbram_addr_q <= 10'd0;
            rows_done_q  <= 1'b0;
            finish_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            k_q          <= k_d;
            g_q          <= g_d;
            rb_q         <= rb_d;
            m_q          <= m_d;
            dcnt_q       <= dcnt_d;
            zsr_q        <= zsr_d;
            lsr_q        <= lsr_d;
            mbram_en_q   <= mbram_en_d;
            mbram_addr_q <= mbram_addr_d;
            vbram_en_q   <= vbram_en_d;
            vbram_we_q   <= vbram_we_d;
            vbram_addr_q <= vbram_addr_d;
            rows_done_q  <= rows_done_d;
            finish_q     <= finish_d;
        end
    end

    assign bus.mbram_clk  = clk;
    assign bus.vbram_clk  = clk;
    assign bus.mbram_en   = mbram_en_q;
    assign bus.mbram_addr = mbram_addr_q;
    assign bus.vbram_en   = vbram_en_q;
    assign bus.vbram_we   = vbram_we_q;
    assign bus.vbram_addr = vbram_addr_q;
    assign bus.zero_in    = zsr_q[L1];
    assign bus.last       = lsr_q[L1];
    assign bus.rows_done  = rows_done_q;
    assign bus.finish     = finish_q;

endmodule

// File: tb/tb_controller.sv
// ---------------------------------------------------------------------------
// tb_controller
//
// Self-checking bench for controller. Each run starts the controller with a
// chosen N and compares every output, every cycle, against a reference
// computed directly from the group timing rules (group period, issue window,
// token offsets, write slot, finish time). Runs may end normally, be aborted
// by dropping running, or be cut short by a mid-run reset.
// ---------------------------------------------------------------------------
module tb_controller;

    localparam int DMUL = 2;
    localparam int DADD = 1;
    localparam int DACC = 3;
    localparam int L1   = 1 + DMUL + DADD;

    logic clk;
    logic rstn;
    int   checks;
    int   errors;

    controller_if bus ();

    controller #(
        .DELAY_MUL (DMUL),
        .DELAY_ADD (DADD),
        .DELAY_ACC (DACC)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {mbram_clk, vbram_clk, mbram_en, mbram_addr, vbram_en, vbram_we,
    //  vbram_addr, zero_in, last, rows_done, finish}
    logic [30:0] obs;
    assign obs = {bus.mbram_clk, bus.vbram_clk, bus.mbram_en, bus.mbram_addr,
                  bus.vbram_en, bus.vbram_we, bus.vbram_addr,
                  bus.zero_in, bus.last, bus.rows_done, bus.finish};

    task automatic check(input string tag, input logic [30:0] got, input logic [30:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Expected outputs at cycle t of a run with dimension n. Sampled just
    // after the rising edge, so both BRAM clocks read 1.
    function automatic logic [30:0] model(input int n, input int t, input int stop_at);
        int          p, groups, g, o;
        logic        m_en, v_en, v_we, zi, la, rd, fin;
        logic [11:0] m_addr;
        logic [9:0]  v_addr;
        m_en = 0; v_en = 0; v_we = 0; zi = 0; la = 0; rd = 0; fin = 0;
        m_addr = '0; v_addr = '0;
        if (t <= stop_at) begin
            p      = n + L1 + DACC + 1;
            groups = (n + 5) / 6;
            if (t >= groups * p) begin
                fin = 1;
            end else begin
                g = t / p;
                o = t % p;
                if (o < n) begin
                    m_en   = 1;
                    m_addr = 12'((g * n + o) % 4096);
                    v_en   = 1;
                    v_addr = 10'(o);
                end
                if (o == L1)         zi = 1;
                if (o == n - 1 + L1) la = 1;
                if (o == n + L1 + DACC) begin
                    v_en   = 1;
                    v_we   = 1;
                    v_addr = 10'(512 + g);
                    rd     = 1;
                end
            end
        end
        return {1'b1, 1'b1, m_en, m_addr, v_en, v_we, v_addr, zi, la, rd, fin};
    endfunction

    // One run: start with dimension n; at cycle stop_at drop running (and
    // optionally pulse reset); keep checking a few idle cycles afterwards.
    task automatic run_case(input string name, input int n, input int stop_at,
                            input bit use_rst);
        @(negedge clk);
        bus.width   = 9'(n);
        bus.running = 1'b1;
        @(posedge clk);
        for (int t = 0; t <= stop_at + 4; t++) begin
            #1;
            check($sformatf("%s n=%0d t=%0d", name, n, t), obs, model(n, t, stop_at));
            rstn = 1'b1;
            if (t == 1) bus.width = 9'($urandom_range(0, 511));
            if (t == stop_at) begin
                bus.running = 1'b0;
                if (use_rst) rstn = 1'b0;
            end
            @(posedge clk);
        end
        $display("run %s n=%0d stop=%0d rst=%0d checks=%0d errors=%0d",
                 name, n, stop_at, use_rst, checks, errors);
    endtask

    function automatic int run_len(input int n);
        return ((n + 5) / 6) * (n + L1 + DACC + 1);
    endfunction

    initial begin
        int n, stop;
        checks      = 0;
        errors      = 0;
        rstn        = 1'b0;
        bus.running = 1'b0;
        bus.width   = 9'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset state", obs, 31'h6000_0000);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("idle after reset", obs, 31'h6000_0000);

        run_case("n13 full",    13, run_len(13) + 3, 1'b0);
        run_case("n6 restart",   6, run_len(6) + 2,  1'b0);
        run_case("n1",           1, run_len(1) + 2,  1'b0);
        run_case("n0",           0, 3,               1'b0);
        run_case("n13 abort",   13, 10,              1'b0);
        run_case("n13 rst drn", 13, 15,              1'b1);
        run_case("n13 after rst", 13, run_len(13) + 1, 1'b0);

        for (int i = 0; i < 12; i++) begin
            n = $urandom_range(1, 60);
            if ($urandom_range(0, 1) == 1)
                stop = $urandom_range(0, run_len(n) + 2);
            else
                stop = run_len(n) + 2;
            run_case("random", n, stop, ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
